wmem_dispatch: RTL and testbench

Clocked, parametrised filter-weight memory. It stores NUM_FILTERS filters of FILTER_SIZE x FILTER_SIZE weights and, on command, packs one filter's weights into router packets: one filter row per PPE, WEIGHTS_PER_PKT weights per packet. After the last weight packet it sends a WEIGHTS_DONE packet to IMEM. It sits between the testbench/loader and the NoC router injection port.

---
 rtl/wmem_pkg.sv | 37 +++
 rtl/wmem_if.sv | 28 ++
 rtl/wmem_pack_row.sv | 32 +++
 rtl/wmem_dispatch.sv | 234 +++++++++++++++++++++++
 tb/tb_wmem_dispatch.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/wmem_pkg.sv
// Shared packet layout, opcodes and FSM encoding for the filter-weight memory.
// Optional redispatch support is enabled with the WMEM_REDISPATCH_EN macro.
package wmem_pkg;

    localparam int DEST_W   = 4;
    localparam int OP_W     = 4;
    localparam int DATA_W   = 25;
    localparam int PKT_W    = DEST_W + OP_W + DATA_W;
    localparam int OP_LSB   = DATA_W;
    localparam int DEST_LSB = DATA_W + OP_W;

    localparam logic [OP_W-1:0]   OP_WEIGHT       = 4'd0;
    localparam logic [OP_W-1:0]   OP_WEIGHTS_DONE = 4'd0;
    localparam logic [DEST_W-1:0] IMEM_ID         = 4'd11;

    typedef struct packed {
        logic [DEST_W-1:0] dest;
        logic [OP_W-1:0]   opcode;
        logic [DATA_W-1:0] data;
    } pkt_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOAD     = 2'd1,
        ST_SEND     = 2'd2,
        ST_DONE_PKT = 2'd3
    } state_t;

    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/wmem_if.sv
// Weight-write bus and router injection handshake of the filter-weight memory.
// The memory itself uses the slave modport; loader/router side uses master.
interface wmem_if
    import wmem_pkg::*;
#(
    parameter int WEIGHT_WIDTH = 8,
    parameter int FILT_W       = 1,
    parameter int ADDR_W       = 5
);
    logic                    wr_valid;
    logic                    wr_ready;
    logic [FILT_W-1:0]       wr_filt;
    logic [ADDR_W-1:0]       wr_addr;
    logic [WEIGHT_WIDTH-1:0] wr_data;
    logic                    pkt_valid;
    logic                    pkt_ready;
    logic [PKT_W-1:0]        pkt_data;

    modport master (
        output wr_valid, wr_filt, wr_addr, wr_data, pkt_ready,
        input  wr_ready, pkt_valid, pkt_data
    );

    modport slave (
        input  wr_valid, wr_filt, wr_addr, wr_data, pkt_ready,
        output wr_ready, pkt_valid, pkt_data
    );
endinterface

// File: rtl/wmem_pack_row.sv
// Combinational packer: selects chunk 'chunk' of filter row 'row' and places
// its weights little-end first in the packet data field, zero-filling the rest.
module wmem_pack_row
    import wmem_pkg::*;
#(
    parameter int WEIGHT_WIDTH    = 8,
    parameter int FILTER_SIZE     = 5,
    parameter int WEIGHTS_PER_PKT = 3,
    parameter int ROW_W           = 3,
    parameter int CHUNK_W         = 1
) (
    input  logic [FILTER_SIZE*FILTER_SIZE*WEIGHT_WIDTH-1:0] bank_flat,
    input  logic [ROW_W-1:0]                                row,
    input  logic [CHUNK_W-1:0]                              chunk,
    output logic [DATA_W-1:0]                               data
);

    // Gather the chunk's weights; columns past the row edge stay zero
    always_comb begin
        data = '0;
        for (int k = 0; k < WEIGHTS_PER_PKT; k++) begin
            if ((int'(chunk) * WEIGHTS_PER_PKT + k) < FILTER_SIZE) begin
                data[k*WEIGHT_WIDTH +: WEIGHT_WIDTH] =
                    bank_flat[(int'(row) * FILTER_SIZE + int'(chunk) * WEIGHTS_PER_PKT + k)
                              * WEIGHT_WIDTH +: WEIGHT_WIDTH];
            end else begin
                data[k*WEIGHT_WIDTH +: WEIGHT_WIDTH] = '0;
            end
        end
    end

endmodule

// File: rtl/wmem_dispatch.sv
// Filter-weight memory: loads NUM_FILTERS banks, then streams one bank as row packets
// to the PPEs followed by a done packet to IMEM. WMEM_REDISPATCH_EN adds 'redispatch'.
module wmem_dispatch
    import wmem_pkg::*;
#(
    parameter int WEIGHT_WIDTH    = 8,
    parameter int FILTER_SIZE     = 5,
    parameter int NUM_FILTERS     = 2,
    parameter int WEIGHTS_PER_PKT = 3,
    parameter int FIRST_PPE_ID    = 5
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             load_start,
    input  logic                             load_done,
    input  logic [width_of(NUM_FILTERS)-1:0] filter_sel,
`ifdef WMEM_REDISPATCH_EN
    input  logic                             redispatch,
`endif
    output logic                             busy,
    output logic                             dispatch_done,
    output logic                             err_addr,
    wmem_if.slave                            bus
);

    localparam int NW      = FILTER_SIZE * FILTER_SIZE;
    localparam int FILT_W  = width_of(NUM_FILTERS);
    localparam int ADDR_W  = width_of(NW);
    localparam int PPR     = ceil_div(FILTER_SIZE, WEIGHTS_PER_PKT);
    localparam int ROW_W   = width_of(FILTER_SIZE);
    localparam int CHUNK_W = width_of(PPR);

    localparam logic [ADDR_W:0]      NW_L        = (ADDR_W + 1)'(NW);
    localparam logic [FILT_W:0]      NF_L        = (FILT_W + 1)'(NUM_FILTERS);
    localparam logic [ROW_W-1:0]     LAST_ROW    = ROW_W'(FILTER_SIZE - 1);
    localparam logic [CHUNK_W-1:0]   LAST_CHUNK  = CHUNK_W'(PPR - 1);
    localparam pkt_t                 DONE_PKT    = '{dest: IMEM_ID, opcode: OP_WEIGHTS_DONE, data: '0};

    if (WEIGHTS_PER_PKT * WEIGHT_WIDTH > DATA_W) begin : g_bad_pack
        $error("WEIGHTS_PER_PKT*WEIGHT_WIDTH exceeds the packet data field");
    end
    if (OP_LSB != DATA_W || DEST_LSB != OP_LSB + OP_W || $bits(pkt_t) != PKT_W) begin : g_bad_layout
        $error("packet field layout is inconsistent");
    end

    state_t                  state_r;
    logic [FILT_W-1:0]       sel_r;
    logic [ROW_W-1:0]        row_r;
    logic [CHUNK_W-1:0]      chunk_r;
    logic                    wr_ready_r;
    logic                    pkt_valid_r;
    logic                    busy_r;
    logic                    dispatch_done_r;
    logic                    err_addr_r;
    pkt_t                    pkt_data_r;
    logic [WEIGHT_WIDTH-1:0] mem_r [NUM_FILTERS][NW];

    logic                          wr_fire_s;
    logic                          wr_commit_s;
    logic                          fwd_s;
    logic                          last_row_s;
    logic                          last_chunk_s;
    logic [FILT_W-1:0]             bank_sel_s;
    logic [ROW_W-1:0]              nxt_row_s;
    logic [CHUNK_W-1:0]            nxt_chunk_s;
    logic [NW*WEIGHT_WIDTH-1:0]    bank_flat_s;
    logic [DATA_W-1:0]             pack_data_s;
    pkt_t                          wt_pkt_s;

    assign wr_fire_s    = bus.wr_valid & wr_ready_r;
    assign wr_commit_s  = wr_fire_s & ({1'b0, bus.wr_addr} < NW_L) & ({1'b0, bus.wr_filt} < NF_L);
    assign last_row_s   = (row_r == LAST_ROW);
    assign last_chunk_s = (chunk_r == LAST_CHUNK);

    // Bank and (row, chunk) of the packet that would be presented after the next edge
    always_comb begin
        bank_sel_s  = sel_r;
        nxt_row_s   = row_r;
        nxt_chunk_s = chunk_r;
        case (state_r)
            ST_IDLE, ST_LOAD: begin
                bank_sel_s  = filter_sel;
                nxt_row_s   = '0;
                nxt_chunk_s = '0;
            end
            ST_SEND: begin
                if (last_chunk_s && !last_row_s) begin
                    nxt_row_s   = row_r + ROW_W'(1);
                    nxt_chunk_s = '0;
                end else if (!last_chunk_s) begin
                    nxt_row_s   = row_r;
                    nxt_chunk_s = chunk_r + CHUNK_W'(1);
                end else begin
                    nxt_row_s   = row_r;
                    nxt_chunk_s = chunk_r;
                end
            end
            default: begin
                bank_sel_s  = sel_r;
                nxt_row_s   = row_r;
                nxt_chunk_s = chunk_r;
            end
        endcase
    end

    // Selected bank view, forwarding a write committed in the same cycle as load_done
    assign fwd_s = wr_commit_s & (bus.wr_filt == bank_sel_s);
    always_comb begin
        bank_flat_s = '0;
        for (int a = 0; a < NW; a++) begin
            if (fwd_s && (bus.wr_addr == ADDR_W'(a))) begin
                bank_flat_s[a*WEIGHT_WIDTH +: WEIGHT_WIDTH] = bus.wr_data;
            end else begin
                bank_flat_s[a*WEIGHT_WIDTH +: WEIGHT_WIDTH] = mem_r[bank_sel_s][a];
            end
        end
    end

    wmem_pack_row #(
        .WEIGHT_WIDTH    (WEIGHT_WIDTH),
        .FILTER_SIZE     (FILTER_SIZE),
        .WEIGHTS_PER_PKT (WEIGHTS_PER_PKT),
        .ROW_W           (ROW_W),
        .CHUNK_W         (CHUNK_W)
    ) u_pack (
        .bank_flat (bank_flat_s),
        .row       (nxt_row_s),
        .chunk     (nxt_chunk_s),
        .data      (pack_data_s)
    );

    // Weight packet for the next (row, chunk)
    always_comb begin
        wt_pkt_s.dest   = DEST_W'(FIRST_PPE_ID + int'(nxt_row_s));
        wt_pkt_s.opcode = OP_WEIGHT;
        wt_pkt_s.data   = pack_data_s;
    end

    // Control FSM with registered outputs, weight storage and sticky address error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= ST_IDLE;
            sel_r           <= '0;
            row_r           <= '0;
            chunk_r         <= '0;
            wr_ready_r      <= 1'b0;
            pkt_valid_r     <= 1'b0;
            busy_r          <= 1'b0;
            dispatch_done_r <= 1'b0;
            err_addr_r      <= 1'b0;
            pkt_data_r      <= '0;
            for (int f = 0; f < NUM_FILTERS; f++) begin
                for (int a = 0; a < NW; a++) begin
                    mem_r[f][a] <= '0;
                end
            end
        end else begin
            dispatch_done_r <= 1'b0;
            if (wr_commit_s) begin
                mem_r[bus.wr_filt][bus.wr_addr] <= bus.wr_data;
            end else if (wr_fire_s) begin
                err_addr_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (load_start) begin
                        state_r    <= ST_LOAD;
                        wr_ready_r <= 1'b1;
                        busy_r     <= 1'b1;
                        err_addr_r <= 1'b0;
                    end
`ifdef WMEM_REDISPATCH_EN
                    else if (redispatch) begin
                        state_r     <= ST_SEND;
                        sel_r       <= filter_sel;
                        row_r       <= '0;
                        chunk_r     <= '0;
                        busy_r      <= 1'b1;
                        pkt_valid_r <= 1'b1;
                        pkt_data_r  <= wt_pkt_s;
                    end
`endif
                end
                ST_LOAD: begin
                    if (load_done) begin
                        state_r     <= ST_SEND;
                        wr_ready_r  <= 1'b0;
                        sel_r       <= filter_sel;
                        row_r       <= '0;
                        chunk_r     <= '0;
                        pkt_valid_r <= 1'b1;
                        pkt_data_r  <= wt_pkt_s;
                    end
                end
                ST_SEND: begin
                    if (bus.pkt_ready) begin
                        if (last_row_s && last_chunk_s) begin
                            state_r    <= ST_DONE_PKT;
                            pkt_data_r <= DONE_PKT;
                        end else begin
                            row_r      <= nxt_row_s;
                            chunk_r    <= nxt_chunk_s;
                            pkt_data_r <= wt_pkt_s;
                        end
                    end
                end
                ST_DONE_PKT: begin
                    if (bus.pkt_ready) begin
                        state_r         <= ST_IDLE;
                        pkt_valid_r     <= 1'b0;
                        pkt_data_r      <= '0;
                        busy_r          <= 1'b0;
                        dispatch_done_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    wr_ready_r  <= 1'b0;
                    pkt_valid_r <= 1'b0;
                    pkt_data_r  <= '0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.wr_ready  = wr_ready_r;
    assign bus.pkt_valid = pkt_valid_r;
    assign bus.pkt_data  = pkt_data_r;
    assign busy          = busy_r;
    assign dispatch_done = dispatch_done_r;
    assign err_addr      = err_addr_r;

endmodule

// File: tb/tb_wmem_dispatch.sv
// Directed self-checking bench for wmem_dispatch at default parameters.
// The redispatch scenario is compiled in only with WMEM_REDISPATCH_EN.
module tb_wmem_dispatch;
    import wmem_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load_start;
    logic       load_done;
    logic [0:0] filter_sel;
    logic       busy;
    logic       dispatch_done;
    logic       err_addr;
`ifdef WMEM_REDISPATCH_EN
    logic       redispatch;
`endif

    wmem_if #(.WEIGHT_WIDTH(8), .FILT_W(1), .ADDR_W(5)) bus ();

    wmem_dispatch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_start    (load_start),
        .load_done     (load_done),
        .filter_sel    (filter_sel),
`ifdef WMEM_REDISPATCH_EN
        .redispatch    (redispatch),
`endif
        .busy          (busy),
        .dispatch_done (dispatch_done),
        .err_addr      (err_addr),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc;
    logic [32:0] got [11];
    logic [7:0]  w   [25];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference packet idx of a dispatch of bank contents w
    function automatic logic [32:0] model(input int idx);
        logic [24:0] d;
        int          row;
        int          ch;
        int          col;
        if (idx == 10) return {4'd11, 4'd0, 25'd0};
        row = idx / 2;
        ch  = idx % 2;
        d   = '0;
        for (int k = 0; k < 3; k++) begin
            col = ch * 3 + k;
            if (col < 5) d[k*8 +: 8] = w[row*5 + col];
        end
        return {4'(5 + row), 4'd0, d};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic write(input logic f, input int a, input logic [7:0] d);
        bus.wr_valid = 1'b1;
        bus.wr_filt  = f;
        bus.wr_addr  = 5'(a);
        bus.wr_data  = d;
        tick();
        bus.wr_valid = 1'b0;
    endtask

    task automatic finish_load(input logic sel, input bit do_wr, input logic f, input int a,
                               input logic [7:0] d);
        load_done    = 1'b1;
        filter_sel   = sel;
        bus.wr_valid = do_wr;
        bus.wr_filt  = f;
        bus.wr_addr  = 5'(a);
        bus.wr_data  = d;
        tick();
        load_done    = 1'b0;
        bus.wr_valid = 1'b0;
        check("valid_rise", bus.pkt_valid, 1'b1);
    endtask

    // Accept all 11 packets; toggle=1 stalls every other cycle
    task automatic collect(input bit toggle, output int cycles);
        logic [32:0] held;
        bit          stalled;
        int          n;
        n       = 0;
        stalled = 1'b0;
        cycles  = 0;
        held    = '0;
        for (int c = 0; c < 200 && n < 11; c++) begin
            bus.pkt_ready = toggle ? ((c % 2) == 0) : 1'b1;
            if (stalled) check("stall_hold", bus.pkt_data, held);
            if (bus.pkt_valid && bus.pkt_ready) begin
                got[n]  = bus.pkt_data;
                n++;
                stalled = 1'b0;
                cycles  = c + 1;
            end else begin
                stalled = bus.pkt_valid;
                held    = bus.pkt_data;
            end
            tick();
        end
        bus.pkt_ready = 1'b1;
        check("pkt_count", n, 11);
    endtask

    task automatic check_seq(input string tag);
        for (int i = 0; i < 11; i++) check($sformatf("%s_pkt%0d", tag, i), got[i], model(i));
    endtask

    task automatic check_done();
        check("done_pulse", dispatch_done, 1'b1);
        check("done_idle_busy", busy, 1'b0);
        check("done_idle_valid", bus.pkt_valid, 1'b0);
        tick();
        check("done_pulse_end", dispatch_done, 1'b0);
    endtask

    initial begin
        rst_n         = 1'b0;
        load_start    = 1'b0;
        load_done     = 1'b0;
        filter_sel    = 1'b0;
        bus.wr_valid  = 1'b0;
        bus.wr_filt   = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.pkt_ready = 1'b0;
`ifdef WMEM_REDISPATCH_EN
        redispatch    = 1'b0;
`endif
        repeat (2) tick();
        check("rst_wr_ready", bus.wr_ready, 1'b0);
        check("rst_pkt_valid", bus.pkt_valid, 1'b0);
        check("rst_pkt_data", bus.pkt_data, 33'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", dispatch_done, 1'b0);
        check("rst_err", err_addr, 1'b0);
        rst_n = 1'b1;
        tick();

        // load_done outside LOAD is ignored
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        check("idle_load_done_ignored", busy, 1'b0);

        // Scenario 1: weights 1..25, continuous ready
        start_load();
        check("load_wr_ready", bus.wr_ready, 1'b1);
        check("load_busy", busy, 1'b1);
        for (int i = 0; i < 25; i++) begin
            w[i] = 8'(i + 1);
            write(1'b0, i, w[i]);
        end
        finish_load(1'b0, 1'b0, 1'b0, 0, 8'h00);
        check("send_wr_ready", bus.wr_ready, 1'b0);
        collect(1'b0, cyc);
        check("s1_cycles", cyc, 11);
        check("s1_pkt0", got[0], 33'h0A0030201);
        check("s1_pkt1", got[1], 33'h0A0000504);
        check("s1_pkt9", got[9], 33'h120001918);
        check("s1_pkt10", got[10], 33'h160000000);
        check_seq("s1");
        check_done();

        // Scenario 2: same contents, ready toggling every cycle
        start_load();
        finish_load(1'b0, 1'b0, 1'b0, 0, 8'h00);
        collect(1'b1, cyc);
        check("s2_cycles", cyc, 21);
        check_seq("s2");
        check_done();

        // Scenario 3: out-of-range address is dropped and flagged
        start_load();
        check("s3_err_clear", err_addr, 1'b0);
        write(1'b0, 25, 8'hEE);
        check("s3_err_set", err_addr, 1'b1);
        finish_load(1'b0, 1'b0, 1'b0, 0, 8'h00);
        collect(1'b0, cyc);
        check_seq("s3");
        check_done();
        check("s3_err_sticky", err_addr, 1'b1);
        start_load();
        check("s3_err_cleared", err_addr, 1'b0);

        // Scenario 4: two banks, dispatch bank 1; last write coincides with load_done
        for (int i = 1; i < 25; i++) begin
            write(1'b0, i, 8'h11);
            write(1'b1, i, 8'h22);
        end
        write(1'b0, 0, 8'h11);
        for (int i = 0; i < 25; i++) w[i] = 8'h22;
        finish_load(1'b1, 1'b1, 1'b1, 0, 8'h22);
        collect(1'b0, cyc);
        check_seq("s4");
        check_done();

        // Scenario 5: reset mid-dispatch, then memory must come back cleared
        start_load();
        for (int i = 0; i < 25; i++) begin
            w[i] = 8'(i + 1);
            write(1'b0, i, w[i]);
        end
        finish_load(1'b0, 1'b0, 1'b0, 0, 8'h00);
        bus.pkt_ready = 1'b1;
        repeat (4) tick();
        check("s5_pkt4_before_rst", bus.pkt_data, model(4));
        #2 rst_n = 1'b0;
        #1;
        check("s5_rst_valid", bus.pkt_valid, 1'b0);
        check("s5_rst_data", bus.pkt_data, 33'd0);
        check("s5_rst_busy", busy, 1'b0);
        check("s5_rst_wr_ready", bus.wr_ready, 1'b0);
        check("s5_rst_done", dispatch_done, 1'b0);
        check("s5_rst_err", err_addr, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        check("s5_idle_after_rst", busy, 1'b0);
        start_load();
        for (int i = 0; i < 25; i++) w[i] = 8'h00;
        w[0]  = 8'h5A;
        w[24] = 8'h7F;
        write(1'b0, 0, w[0]);
        write(1'b0, 24, w[24]);
        finish_load(1'b0, 1'b0, 1'b0, 0, 8'h00);
        collect(1'b0, cyc);
        check("s5_cycles", cyc, 11);
        check_seq("s5");
        check_done();

`ifdef WMEM_REDISPATCH_EN
        // Scenario 6: redispatch the same bank without reloading
        redispatch = 1'b1;
        filter_sel = 1'b0;
        tick();
        redispatch = 1'b0;
        check("s6_valid_rise", bus.pkt_valid, 1'b1);
        collect(1'b0, cyc);
        check_seq("s6");
        check_done();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
